// File: rtl/dest_pkg.sv
// Shared types for the destination-register tracker: stage record, FSM states, latency limit.
package dest_pkg;

  localparam int MEM_LAT_MAX = 8;
  // Stage records carry a fixed-width dest; trackers zero-extend narrower specifiers into it.
  localparam int REG_W_MAX   = 16;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dest;
    logic                 regw;
    logic                 load;
  } stage_rec_t;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

endpackage

// File: rtl/dest_tracker_if.sv
// Decode-side request and hazard/writeback status bundle between the pipeline and the tracker.
interface dest_tracker_if #(parameter int WIDTH = 5);
  logic             IssueD;
  logic [WIDTH-1:0] RegDD;
  logic             RegWD;
  logic             MemToRegD;
  logic [WIDTH-1:0] RegS1D;
  logic [WIDTH-1:0] RegS2D;
  logic             FlushE;
  logic [WIDTH-1:0] WriteRegM;
  logic             RegWM;
  logic [WIDTH-1:0] WriteRegWB;
  logic             RegWWB;
  logic             StallD;
  logic             StallP;

  modport master (
    output IssueD, RegDD, RegWD, MemToRegD, RegS1D, RegS2D, FlushE,
    input  WriteRegM, RegWM, WriteRegWB, RegWWB, StallD, StallP
  );

  modport slave (
    input  IssueD, RegDD, RegWD, MemToRegD, RegS1D, RegS2D, FlushE,
    output WriteRegM, RegWM, WriteRegWB, RegWWB, StallD, StallP
  );
endinterface

// File: rtl/dest_stage.sv
// One pipeline stage record: holds when frozen, loads a bubble or the upstream record otherwise.
module dest_stage
  import dest_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       bubble,
  input  stage_rec_t rec_in,
  output stage_rec_t rec_q
);

  stage_rec_t rec_d;

  always_comb begin
    rec_d = rec_q;
    if (!hold) begin
      rec_d = bubble ? '0 : rec_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rec_q <= '0;
    else      rec_q <= rec_d;
  end

endmodule

// File: rtl/dest_tracker.sv
// Tracks destination registers through E/M/WB, raises load-use stalls and freezes the
// pipeline while a load sits in Memory for MEM_LAT cycles.
module dest_tracker
  import dest_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  dest_tracker_if.slave bus
);

  // Out-of-range latencies are clamped into the supported 1..MEM_LAT_MAX window.
  localparam int LAT   = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : ((MEM_LAT < 1) ? 1 : MEM_LAT);
  localparam int CNT_W = $clog2(LAT) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_rec_t       e_q, m_q, wb_q, dec_rec;
  logic             stall_p, stall_d, e_bubble;
  logic             unused_wb_load;

  assign stall_p        = (state_q == ST_MEMWAIT);
  assign unused_wb_load = wb_q.load;

  always_comb begin
    stall_d = bus.IssueD & e_q.valid & e_q.load & e_q.regw & (e_q.dest != '0) &
              ((e_q.dest == REG_W_MAX'(bus.RegS1D)) | (e_q.dest == REG_W_MAX'(bus.RegS2D))) &
              ~stall_p;
    dec_rec  = '{valid: 1'b1, dest: REG_W_MAX'(bus.RegDD), regw: bus.RegWD, load: bus.MemToRegD};
    e_bubble = ~(bus.IssueD & ~stall_d & ~bus.FlushE);
  end

  dest_stage u_stage_e (
    .clk(clk), .rst(rst), .hold(stall_p), .bubble(e_bubble), .rec_in(dec_rec), .rec_q(e_q)
  );

  dest_stage u_stage_m (
    .clk(clk), .rst(rst), .hold(stall_p), .bubble(1'b0), .rec_in(e_q), .rec_q(m_q)
  );

  dest_stage u_stage_wb (
    .clk(clk), .rst(rst), .hold(stall_p), .bubble(1'b0), .rec_in(m_q), .rec_q(wb_q)
  );

  // The counter runs MEM_LAT-2 .. 0, giving MEM_LAT-1 frozen cycles plus the entry cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if ((LAT > 1) && e_q.valid && e_q.load) begin
          state_d = ST_MEMWAIT;
          cnt_d   = CNT_W'(LAT - 2);
        end
      end
      ST_MEMWAIT: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.WriteRegM  = m_q.valid  ? m_q.dest[WIDTH-1:0]  : '0;
  assign bus.RegWM      = m_q.valid  & m_q.regw  & (m_q.dest  != '0);
  assign bus.WriteRegWB = wb_q.valid ? wb_q.dest[WIDTH-1:0] : '0;
  assign bus.RegWWB     = wb_q.valid & wb_q.regw & (wb_q.dest != '0);
  assign bus.StallD     = stall_d;
  assign bus.StallP     = stall_p;

endmodule

// File: tb/tb_dest_tracker.sv
// Directed bench for dest_tracker (MEM_LAT=3) with a per-cycle reference model of instruction flow.
module tb_dest_tracker;

  localparam int W   = 5;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dest_tracker_if #(.WIDTH(W)) bus ();

  dest_tracker #(.WIDTH(W), .MEM_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    bit         valid;
    logic [W-1:0] dest;
    bit         regw;
    bit         load;
  } rec_t;

  // Model: instructions move E->M->WB; a load stays in M for LAT visible cycles, freezing
  // everything until its last one.
  rec_t me = '{default: 0};
  rec_t mm = '{default: 0};
  rec_t mw = '{default: 0};
  int   m_age = 0;

  function automatic bit mdl_stallp();
    return mm.valid && mm.load && (m_age < LAT);
  endfunction

  function automatic bit mdl_stalld();
    return bus.IssueD && me.valid && me.load && me.regw && (me.dest != 0) &&
           (me.dest == bus.RegS1D || me.dest == bus.RegS2D) && !mdl_stallp();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      me = '{default: 0};
      mm = '{default: 0};
      mw = '{default: 0};
      m_age = 0;
    end else if (!mdl_stallp()) begin
      bit issue;
      issue = bus.IssueD && !mdl_stalld() && !bus.FlushE;
      mw = mm;
      mm = me;
      m_age = 1;
      if (issue) me = '{valid: 1, dest: bus.RegDD, regw: bus.RegWD, load: bus.MemToRegD};
      else       me = '{default: 0};
    end else begin
      m_age++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_WriteRegM",  32'(bus.WriteRegM),  mm.valid ? 32'(mm.dest) : 0);
    chk("cyc_RegWM",      32'(bus.RegWM),      32'(mm.valid && mm.regw && mm.dest != 0));
    chk("cyc_WriteRegWB", 32'(bus.WriteRegWB), mw.valid ? 32'(mw.dest) : 0);
    chk("cyc_RegWWB",     32'(bus.RegWWB),     32'(mw.valid && mw.regw && mw.dest != 0));
    chk("cyc_StallP",     32'(bus.StallP),     32'(mdl_stallp()));
    chk("cyc_StallD",     32'(bus.StallD),     32'(mdl_stalld()));
  end

  task automatic drive(input bit iss, input int rd, input bit rw, input bit ld,
                       input int s1, input int s2, input bit fl);
    bus.IssueD    = iss;
    bus.RegDD     = W'(rd);
    bus.RegWD     = rw;
    bus.MemToRegD = ld;
    bus.RegS1D    = W'(s1);
    bus.RegS2D    = W'(s2);
    bus.FlushE    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_WriteRegM", 32'(bus.WriteRegM), 0);
    chk("rst_RegWWB",    32'(bus.RegWWB),    0);
    chk("rst_StallP",    32'(bus.StallP),    0);
    rst = 1'b1;

    // simple ALU write to r9
    drive(1, 9, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("alu_WriteRegM", 32'(bus.WriteRegM), 9);
    chk("alu_RegWM",     32'(bus.RegWM),     1);
    tick();
    chk("alu_WriteRegWB", 32'(bus.WriteRegWB), 9);
    chk("alu_RegWWB",     32'(bus.RegWWB),     1);
    idle(3);

    // write to r0 is never flagged
    drive(1, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("r0_RegWM", 32'(bus.RegWM), 0);
    tick();
    chk("r0_RegWWB", 32'(bus.RegWWB), 0);
    idle(3);

    // flushed instruction never reaches M
    drive(1, 7, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("flush_RegWM",     32'(bus.RegWM),     0);
    chk("flush_WriteRegM", 32'(bus.WriteRegM), 0);
    idle(3);

    // load-use on r9 via source 2
    drive(1, 9, 1, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 9, 0);
    #1;
    chk("lu_StallD", 32'(bus.StallD), 1);
    tick();
    chk("lu_StallD_after", 32'(bus.StallD), 0);
    chk("lu_StallP",       32'(bus.StallP), 1);
    tick();
    tick();
    chk("lu_release", 32'(bus.StallP), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lu_WriteRegWB", 32'(bus.WriteRegWB), 9);
    tick();
    chk("lu_dep_WriteRegM", 32'(bus.WriteRegM), 5);
    chk("lu_dep_RegWM",     32'(bus.RegWM),     1);
    idle(3);

    // load to r4, MEM_LAT=3 -> two frozen cycles
    drive(1, 4, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ld4_StallP_1", 32'(bus.StallP), 1);
    chk("ld4_WrM_1",    32'(bus.WriteRegM), 4);
    tick();
    chk("ld4_StallP_2", 32'(bus.StallP), 1);
    chk("ld4_WrM_2",    32'(bus.WriteRegM), 4);
    tick();
    chk("ld4_StallP_3", 32'(bus.StallP), 0);
    chk("ld4_RegWM",    32'(bus.RegWM), 1);
    tick();
    chk("ld4_WriteRegWB", 32'(bus.WriteRegWB), 4);
    chk("ld4_RegWWB",     32'(bus.RegWWB), 1);
    idle(3);

    // load to r0 with matching source 0 never stalls Decode
    drive(1, 0, 1, 1, 0, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0);
    #1;
    chk("ldr0_StallD", 32'(bus.StallD), 0);
    idle(6);

    // back-to-back loads r1, r2
    drive(1, 1, 1, 1, 0, 0, 0);
    tick();
    drive(1, 2, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("b2b_first_M",  32'(bus.WriteRegM), 1);
    chk("b2b_gap",      32'(bus.StallP), 0);
    tick();
    chk("b2b_second_M", 32'(bus.WriteRegM), 2);
    chk("b2b_second_P", 32'(bus.StallP), 1);
    chk("b2b_first_WB", 32'(bus.WriteRegWB), 1);
    idle(6);

    // asynchronous reset in the middle of a memory wait
    drive(1, 6, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ar_pre_StallP", 32'(bus.StallP), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_StallP",    32'(bus.StallP),    0);
    chk("ar_WriteRegM", 32'(bus.WriteRegM), 0);
    chk("ar_RegWM",     32'(bus.RegWM),     0);
    chk("ar_StallD",    32'(bus.StallD),    0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_after_StallP", 32'(bus.StallP), 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_tracker.md
DEST_TRACKER -- requirements
Module: dest_tracker

Interface
REQ-001 Parameter WIDTH, default 5, register-specifier width.
REQ-002 Parameter MEM_LAT, default 2, cycles a load occupies Memory (legal 1..8).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 IssueD  in  1  valid instruction in Decode.
REQ-006 RegDD  in  WIDTH  destination register of Decode instruction.
REQ-007 RegWD  in  1  Decode instruction writes the register file.
REQ-008 MemToRegD  in  1  Decode instruction is a load.
REQ-009 RegS1D  in  WIDTH  source 1 of Decode instruction.
REQ-010 RegS2D  in  WIDTH  source 2 of Decode instruction.
REQ-011 FlushE  in  1  kill instruction entering Execute (taken branch).
REQ-012 WriteRegM  out  WIDTH  destination held in Memory stage.
REQ-013 RegWM  out  1  Memory-stage instruction writes a nonzero register.
REQ-014 WriteRegWB  out  WIDTH  destination held in Writeback stage.
REQ-015 RegWWB  out  1  Writeback-stage instruction writes a nonzero register.
REQ-016 StallD  out  1  hold Fetch/Decode, bubble into Execute (load-use).
REQ-017 StallP  out  1  freeze entire pipeline (load waiting on memory).

Function
REQ-018 Three stage records E, M, WB, each {valid, dest, regw, load}.
REQ-019 StallP=0 edge: WB<=M, M<=E, E<=D record if IssueD & !StallD & !FlushE, else bubble (valid=0).
REQ-020 StallP=1 edge: E, M, WB hold; IssueD, FlushE ignored.
REQ-021 FlushE and StallD together: bubble into E (flush wins, same result).
REQ-022 StallD = IssueD & E.valid & E.load & E.regw & E.dest!=0 & (E.dest==RegS1D | E.dest==RegS2D) & !StallP; only combinational input-to-output path.
REQ-023 RegWM = M.valid & M.regw & M.dest!=0; RegWWB likewise from WB; register 0 never flagged.
REQ-024 WriteRegM/WriteRegWB = stage dest, forced 0 when stage invalid.
REQ-025 FSM states RUN, MEMWAIT; StallP = (state==MEMWAIT), registered.
REQ-026 RUN->MEMWAIT on edge where E.valid & E.load advances into M and MEM_LAT>1; counter<=MEM_LAT-2.
REQ-027 MEMWAIT: counter decrements each edge; ->RUN on edge where counter==0; StallP high exactly MEM_LAT-1 cycles.
REQ-028 MEM_LAT=1: FSM never leaves RUN, StallP constant 0.
REQ-029 Counter width $clog2(MEM_LAT)+1, unsigned, never wraps below 0.
REQ-030 Back-to-back loads: second load enters M only after first leaves MEMWAIT; each gets full MEM_LAT.

Reset
REQ-031 rst low: all valid bits 0, dest 0, state RUN, counter 0, immediately (asynchronous).
REQ-032 Output values during reset: WriteRegM=0, RegWM=0, WriteRegWB=0, RegWWB=0, StallP=0, StallD=0.
REQ-033 Reset mid-MEMWAIT aborts wait; first edge after release behaves as RUN with empty pipeline.

Structure
REQ-034 Package dest_pkg holds stage-record struct typedef, FSM state enum, MEM_LAT_MAX=8.
REQ-035 One sub-module dest_stage: single stage record register with hold and bubble inputs, instantiated three times.

Verification
REQ-036 Reset release, IssueD=1 RegDD=9 RegWD=1 -> two edges later WriteRegM=9 RegWM=1, three edges later WriteRegWB=9 RegWWB=1.
REQ-037 Load RegDD=9 in E, Decode RegS2D=9 -> StallD=1 one cycle, bubble in E, dependent issues next cycle.
REQ-038 MEM_LAT=3, load to r4 -> StallP=1 exactly 2 cycles after load enters M, WriteRegM=4 held, then WriteRegWB=4.
REQ-039 RegDD=0 RegWD=1 -> RegWM and RegWWB stay 0; load to r0 with RegS1D=0 -> StallD=0.
REQ-040 FlushE=1 with IssueD=1 RegDD=7 -> RegWM stays 0 two edges later.
REQ-041 rst low during MEMWAIT -> StallP=0 and all outputs 0 without a clock edge.
